// File: rtl/vmac_sequencer.sv
// vmac_sequencer
//   Issue/writeback controller for the vector multiply-accumulate datapath.
//   Accepts one vmacc-class instruction at a time, reads vs1/vs2/vd from the
//   vector register file, presents the operands to the MAC, waits for
//   mac_done_i and writes the result back to vd under a vl-derived mask.
//
//   Sequence: IDLE -> RD -> CAP -> EXEC -> WB -> IDLE.
//   Every output comes from a register; there is no input-to-output path.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   instr_valid_i/ready_o  instruction handshake (ready only in IDLE)
//   vs1_i, vs2_i, vd_idx_i source/destination register indices
//   vl_i                   active element count, clamped to VL
//   instr_done_o           one-cycle completion pulse
//   rf_ren_o, rf_raddr*_o  register-file read strobe and addresses
//   rf_rdata*_i            read data, valid the cycle after rf_ren_o
//   mac_vector_a/b_o,
//   mac_vd_o, mac_valid_o  MAC operands and request (held through EXEC)
//   mac_done_i, mac_result_i  MAC completion and result
//   rf_we_o, rf_waddr_o,
//   rf_wdata_o, rf_wstrb_o writeback port with per-element enables
//   err_o                  sticky EXEC timeout flag
//
// Configuration
//   VMAC_TIMEOUT_EN  when defined, an EXEC watchdog of TIMEOUT cycles aborts
//                    the instruction (no writeback) and sets err_o. When
//                    undefined, EXEC waits indefinitely and err_o is 0.
module vmac_sequencer #(
  parameter int VL      = 8,
  parameter int SEW     = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [4:0]        vs1_i,
  input  logic [4:0]        vs2_i,
  input  logic [4:0]        vd_idx_i,
  input  logic [3:0]        vl_i,
  output logic              instr_done_o,
  output logic              rf_ren_o,
  output logic [4:0]        rf_raddr0_o,
  output logic [4:0]        rf_raddr1_o,
  output logic [4:0]        rf_raddr2_o,
  input  logic [VL*SEW-1:0] rf_rdata0_i,
  input  logic [VL*SEW-1:0] rf_rdata1_i,
  input  logic [VL*SEW-1:0] rf_rdata2_i,
  output logic [VL*SEW-1:0] mac_vector_a_o,
  output logic [VL*SEW-1:0] mac_vector_b_o,
  output logic [VL*SEW-1:0] mac_vd_o,
  output logic              mac_valid_o,
  input  logic              mac_done_i,
  input  logic [VL*SEW-1:0] mac_result_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [VL*SEW-1:0] rf_wdata_o,
  output logic [VL-1:0]     rf_wstrb_o,
  output logic              err_o
);

  localparam int W = VL * SEW;
  // vl_i is only 4 bits wide, so a VL above 15 can never clamp.
  localparam logic [4:0] VL_MAX = (VL > 15) ? 5'd15 : 5'(VL);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EXEC, S_WB} state_e;

  state_e        state_q;
  logic          instr_ready_q, instr_done_q, rf_ren_q, rf_we_q, mac_valid_q;
  logic [4:0]    vs1_q, vs2_q, vd_q;
  logic [VL-1:0] wstrb_q;
  logic [W-1:0]  opa_q, opb_q, opc_q, result_q;

  logic [4:0]    vl_clamped;
  logic [VL-1:0] wstrb_d;

  assign vl_clamped = ({1'b0, vl_i} > VL_MAX) ? VL_MAX : {1'b0, vl_i};

  // Element i is written iff i < clamped vl.
  genvar gi;
  generate
    for (gi = 0; gi < VL; gi++) begin : g_strb
      assign wstrb_d[gi] = (gi < 32'(vl_clamped));
    end
  endgenerate

`ifdef VMAC_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_ready_q <= 1'b1;
      instr_done_q  <= 1'b0;
      rf_ren_q      <= 1'b0;
      rf_we_q       <= 1'b0;
      mac_valid_q   <= 1'b0;
      vs1_q         <= '0;
      vs2_q         <= '0;
      vd_q          <= '0;
      wstrb_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      opc_q         <= '0;
      result_q      <= '0;
`ifdef VMAC_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low.
      rf_ren_q     <= 1'b0;
      rf_we_q      <= 1'b0;
      instr_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid_i) begin
            vs1_q   <= vs1_i;
            vs2_q   <= vs2_i;
            vd_q    <= vd_idx_i;
            wstrb_q <= wstrb_d;
            if (vl_clamped == 5'd0) begin
              // Nothing to do: complete without touching RF or MAC.
              instr_done_q <= 1'b1;
            end else begin
              state_q       <= S_RD;
              rf_ren_q      <= 1'b1;
              instr_ready_q <= 1'b0;
            end
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          opa_q       <= rf_rdata0_i;
          opb_q       <= rf_rdata1_i;
          opc_q       <= rf_rdata2_i;
          mac_valid_q <= 1'b1;
          state_q     <= S_EXEC;
`ifdef VMAC_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        S_EXEC: begin
          // mac_done_i has priority, including on the last watchdog cycle.
          if (mac_done_i) begin
            result_q     <= mac_result_i;
            mac_valid_q  <= 1'b0;
            rf_we_q      <= 1'b1;
            instr_done_q <= 1'b1;
            state_q      <= S_WB;
          end
`ifdef VMAC_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            mac_valid_q   <= 1'b0;
            err_q         <= 1'b1;
            instr_done_q  <= 1'b1;
            instr_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_WB: begin
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          mac_valid_q   <= 1'b0;
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o  = instr_ready_q;
  assign instr_done_o   = instr_done_q;
  assign rf_ren_o       = rf_ren_q;
  assign rf_raddr0_o    = vs1_q;
  assign rf_raddr1_o    = vs2_q;
  assign rf_raddr2_o    = vd_q;
  assign mac_vector_a_o = opa_q;
  assign mac_vector_b_o = opb_q;
  assign mac_vd_o       = opc_q;
  assign mac_valid_o    = mac_valid_q;
  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = vd_q;
  assign rf_wdata_o     = result_q;
  assign rf_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_vmac_sequencer.sv
// Testbench for vmac_sequencer: register-file and MAC environment models,
// instruction-level reference (vd = vs1*vs2 + vd per element, masked by the
// clamped vl, with the documented cycle schedule), directed and random
// instructions.
module tb_vmac_sequencer;
  localparam int VL  = 8;
  localparam int SEW = 32;
  localparam int W   = VL * SEW;
`ifdef VMAC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 4;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 64;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic instr_valid, instr_ready, instr_done;
  logic [4:0] vs1, vs2, vd_idx;
  logic [3:0] vl;
  logic rf_ren, mac_valid, mac_done, rf_we, err;
  logic [4:0] rf_raddr0, rf_raddr1, rf_raddr2, rf_waddr;
  logic [W-1:0] rf_rdata0, rf_rdata1, rf_rdata2;
  logic [W-1:0] mac_a, mac_b, mac_vd, mac_result, rf_wdata;
  logic [VL-1:0] rf_wstrb;

  always #5 clk = ~clk;

  vmac_sequencer #(.VL(VL), .SEW(SEW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .vs1_i(vs1), .vs2_i(vs2), .vd_idx_i(vd_idx), .vl_i(vl),
    .instr_done_o(instr_done),
    .rf_ren_o(rf_ren), .rf_raddr0_o(rf_raddr0), .rf_raddr1_o(rf_raddr1),
    .rf_raddr2_o(rf_raddr2),
    .rf_rdata0_i(rf_rdata0), .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
    .mac_vector_a_o(mac_a), .mac_vector_b_o(mac_b), .mac_vd_o(mac_vd),
    .mac_valid_o(mac_valid), .mac_done_i(mac_done), .mac_result_i(mac_result),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_wstrb_o(rf_wstrb), .err_o(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mac_delay = 0;
  int exec_cnt  = 0;
  bit exp_err   = 1'b0;
  logic [W-1:0] rf [32];
  bit rd_pend = 1'b0;
  logic [4:0] rd_a0, rd_a1, rd_a2;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int e = 0; e < VL; e++) r[e*SEW +: SEW] = SEW'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] vmac(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0]   r;
    logic [SEW-1:0] ea, eb, ec;
    for (int e = 0; e < VL; e++) begin
      ea = a[e*SEW +: SEW];
      eb = b[e*SEW +: SEW];
      ec = c[e*SEW +: SEW];
      r[e*SEW +: SEW] = ea * eb + ec;
    end
    return r;
  endfunction

  // Advance one cycle, sample 1ns after the edge, then drive the RF read
  // data (registered read: data for the cycle after rf_ren) and the MAC.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend) begin
      rf_rdata0 = rf[rd_a0];
      rf_rdata1 = rf[rd_a1];
      rf_rdata2 = rf[rd_a2];
    end else begin
      rf_rdata0 = rand_vec();
      rf_rdata1 = rand_vec();
      rf_rdata2 = rand_vec();
    end
    rd_pend = rf_ren;
    rd_a0 = rf_raddr0;
    rd_a1 = rf_raddr1;
    rd_a2 = rf_raddr2;
    if (mac_valid) begin
      if (exec_cnt == mac_delay) begin
        mac_done   = 1'b1;
        mac_result = vmac(mac_a, mac_b, mac_vd);
      end else begin
        mac_done   = 1'b0;
        mac_result = rand_vec();
      end
      exec_cnt++;
    end else begin
      exec_cnt   = 0;
      mac_done   = 1'($urandom_range(0, 1));  // must be ignored outside EXEC
      mac_result = rand_vec();
    end
  endtask

  // Issue one instruction (MAC answers after k extra EXEC cycles) and check
  // everything it does until instr_ready returns. With hold set, instr_valid
  // stays asserted while busy so the next call's instruction waits in line.
  task automatic run_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic [3:0] v, input int k, input bit hold);
    int vlc, bound, end_cyc, ren_cnt, ren_cyc, we_cnt, we_cyc, done_cnt, done_cyc, mv_cnt;
    logic [W-1:0] ea, eb, ec, eres, opa, opb, opc, wd;
    logic [VL-1:0] emask, ws;
    logic [4:0] ra0, ra1, ra2, wa;
    bit tmo, op_bad;
    for (int i = 0; i < 50 && instr_ready !== 1'b1; i++) tick();
    check("ready_before_issue", instr_ready, 1);
    vlc = (int'(v) > VL) ? VL : int'(v);
    for (int e = 0; e < VL; e++) emask[e] = (e < vlc);
    ea = rf[s1]; eb = rf[s2]; ec = rf[d];
    eres = vmac(ea, eb, ec);
    tmo = TMO_EN && (vlc != 0) && (k >= TMO);
    mac_delay = k;
    vs1 = s1; vs2 = s2; vd_idx = d; vl = v; instr_valid = 1'b1;
    cyc = 0;
    end_cyc = -1; ren_cnt = 0; ren_cyc = -1; we_cnt = 0; we_cyc = -1;
    done_cnt = 0; done_cyc = -1; mv_cnt = 0; op_bad = 1'b0;
    opa = '0; opb = '0; opc = '0; wd = '0; ws = '0; wa = '0; ra0 = '0; ra1 = '0; ra2 = '0;
    bound = 30 + ((k > 100) ? 100 : k);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (i == 0) instr_valid = hold;
      if (rf_ren) begin
        if (ren_cnt == 0) begin ren_cyc = cyc; ra0 = rf_raddr0; ra1 = rf_raddr1; ra2 = rf_raddr2; end
        ren_cnt++;
      end
      if (mac_valid) begin
        if (mv_cnt == 0) begin opa = mac_a; opb = mac_b; opc = mac_vd; end
        else if (mac_a !== opa || mac_b !== opb || mac_vd !== opc) op_bad = 1'b1;
        mv_cnt++;
      end
      if (rf_we) begin
        if (we_cnt == 0) begin we_cyc = cyc; wa = rf_waddr; wd = rf_wdata; ws = rf_wstrb; end
        we_cnt++;
      end
      if (instr_done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
      if (instr_ready) begin end_cyc = cyc; break; end
    end
    if (vlc == 0) begin
      check("zero_ren_cnt", ren_cnt, 0);
      check("zero_mac_valid_cnt", mv_cnt, 0);
      check("zero_we_cnt", we_cnt, 0);
      check("zero_done_cnt", done_cnt, 1);
      check("zero_done_cycle", done_cyc, 1);
      check("zero_ready_cycle", end_cyc, 1);
    end else begin
      check("ren_cnt", ren_cnt, 1);
      check("ren_cycle", ren_cyc, 1);
      check("raddr0", ra0, s1);
      check("raddr1", ra1, s2);
      check("raddr2", ra2, d);
      check("mac_a", opa, ea);
      check("mac_b", opb, eb);
      check("mac_vd", opc, ec);
      check("operands_stable", op_bad, 0);
      check("done_cnt", done_cnt, 1);
      if (tmo) begin
        exp_err = 1'b1;
        check("tmo_mac_valid_cnt", mv_cnt, TMO);
        check("tmo_we_cnt", we_cnt, 0);
        check("tmo_done_cycle", done_cyc, 3 + TMO);
        check("tmo_ready_cycle", end_cyc, 3 + TMO);
      end else begin
        check("mac_valid_cnt", mv_cnt, k + 1);
        check("we_cnt", we_cnt, 1);
        check("we_cycle", we_cyc, 4 + k);
        check("waddr", wa, d);
        check("wstrb", ws, emask);
        check("wdata", wd, eres);
        check("done_cycle", done_cyc, 4 + k);
        check("ready_cycle", end_cyc, 5 + k);
        for (int e = 0; e < VL; e++)
          if (emask[e]) rf[d][e*SEW +: SEW] = eres[e*SEW +: SEW];
      end
    end
    check("err", err, exp_err);
    $display("instr vs1=%0d vs2=%0d vd=%0d vl=%0d delay=%0d hold=%0d done@%0d we=%0d strb=%0h",
             s1, s2, d, v, k, hold, done_cyc, we_cnt, ws);
  endtask

  initial begin
    int cnt_we, cnt_done, cnt_mv, cnt_ren;
    for (int r = 0; r < 32; r++) rf[r] = rand_vec();
    for (int e = 0; e < VL; e++) begin
      rf[1][e*SEW +: SEW] = SEW'(32'h3);
      rf[2][e*SEW +: SEW] = SEW'(32'h4);
      rf[3][e*SEW +: SEW] = SEW'(32'h10);
    end
    rst_n = 1'b0; instr_valid = 1'b0; vs1 = '0; vs2 = '0; vd_idx = '0; vl = '0;
    mac_done = 1'b0; mac_result = '0; rf_rdata0 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    tick(); tick();
    check("rst_instr_ready", instr_ready, 1);
    check("rst_rf_ren", rf_ren, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_mac_valid", mac_valid, 0);
    check("rst_instr_done", instr_done, 0);
    check("rst_err", err, 0);
    check("rst_wstrb", rf_wstrb, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_raddr0", rf_raddr0, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    tick();

    // Basic: every element 3*4+0x10 = 0x1C, full mask.
    run_instr(5'd1, 5'd2, 5'd3, 4'd8, 0, 1'b0);
    for (int e = 0; e < VL; e++) check("basic_elem", rf[3][e*SEW +: SEW], 32'h1C);
    run_instr(5'd4, 5'd5, 5'd6, 4'd5, 1, 1'b0);   // partial vl
    run_instr(5'd7, 5'd8, 5'd9, 4'd12, 2, 1'b0);  // clamped vl
    run_instr(5'd1, 5'd2, 5'd10, 4'd0, 0, 1'b0);  // zero vl
    run_instr(5'd1, 5'd2, 5'd3, 4'd8, 10, 1'b1);  // long MAC, next offered while busy
    run_instr(5'd3, 5'd3, 5'd3, 4'd6, 0, 1'b0);   // vd aliases both sources
`ifdef VMAC_TIMEOUT_EN
    run_instr(5'd11, 5'd12, 5'd13, 4'd8, 1000, 1'b0);   // watchdog fires
    run_instr(5'd11, 5'd12, 5'd14, 4'd8, TMO - 1, 1'b0); // done on last counted cycle
`endif

    // Reset in the middle of EXEC.
    for (int i = 0; i < 50 && instr_ready !== 1'b1; i++) tick();
    mac_delay = 1000;
    vs1 = 5'd5; vs2 = 5'd6; vd_idx = 5'd7; vl = 4'd8; instr_valid = 1'b1;
    cyc = 0;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    check("rstmid_pre_mac_valid", mac_valid, 1);
    rst_n = 1'b0;
    tick();
    check("rstmid_mac_valid", mac_valid, 0);
    check("rstmid_instr_ready", instr_ready, 1);
    check("rstmid_rf_we", rf_we, 0);
    check("rstmid_mac_a", mac_a, 0);
    check("rstmid_err", err, 0);
    rst_n = 1'b1;
    exp_err = 1'b0;
    cnt_we = 0; cnt_done = 0; cnt_mv = 0; cnt_ren = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt_we += int'(rf_we); cnt_done += int'(instr_done);
      cnt_mv += int'(mac_valid); cnt_ren += int'(rf_ren);
    end
    check("rstmid_after_we", cnt_we, 0);
    check("rstmid_after_done", cnt_done, 0);
    check("rstmid_after_mac_valid", cnt_mv, 0);
    check("rstmid_after_ren", cnt_ren, 0);
    run_instr(5'd5, 5'd6, 5'd7, 4'd8, 1, 1'b0);

    // Random instructions.
    for (int n = 0; n < 24; n++) begin
      run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), $urandom_range(0, 6),
                (n != 23) && ($urandom_range(0, 3) == 0));
    end
    instr_valid = 1'b0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vmac_sequencer.md
# vmac_sequencer

Issue and writeback controller for the vector multiply-accumulate datapath. It accepts one `vmacc`-class instruction at a time and reads `vs1`, `vs2` and `vd` from the vector register file. It drives the MAC operand and valid interface, waits for the MAC to signal done, and writes the result back to `vd` under an element mask derived from `vl`. It sits between the decode stage and the MAC unit.

## Interface
- `VL`, default 8: elements per vector register.
- `SEW`, default 32: element width in bits.
- `TIMEOUT`, default 64: EXEC watchdog limit in cycles. Used only with `VMAC_TIMEOUT_EN`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `vs1`, `vs2`, `vd_idx`  in  5 each  register indices.
- `vl`  in  4  active element count, 0..15; values above `VL` are clamped to `VL`.
- `instr_done`  out  1  one-cycle completion pulse.
- `rf_ren`  out  1  register-file read strobe.
- `rf_raddr0`, `rf_raddr1`, `rf_raddr2`  out  5 each  read addresses for `vs1`, `vs2` and `vd`.
- `rf_rdata0`, `rf_rdata1`, `rf_rdata2`  in  VL*SEW each  read data, valid the cycle after `rf_ren`.
- `mac_vector_a`, `mac_vector_b`, `mac_vd`  out  VL*SEW each  MAC operands.
- `mac_valid`  out  1  MAC request. Held high through EXEC.
- `mac_done`  in  1  MAC result valid.
- `mac_result`  in  VL*SEW  MAC result.
- `rf_we`  out  1  writeback strobe.
- `rf_waddr`  out  5  writeback address.
- `rf_wdata`  out  VL*SEW  writeback data.
- `rf_wstrb`  out  VL  per-element write enable.
- `err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, RD, CAP, EXEC, WB.
- **IDLE**
  - `instr_ready=1`.
  - On `instr_valid`, latch `vs1`, `vs2`, `vd_idx` and the clamped `vl`.
  - If the clamped `vl` is 0: stay in IDLE, pulse `instr_done` next cycle, make no register-file or MAC access.
  - Otherwise go to RD.
- **RD**
  - `rf_ren=1` for exactly one cycle.
  - `rf_raddr0/1/2` = `vs1`, `vs2`, `vd_idx`.
  - Go to CAP.
- **CAP**
  - Register `rf_rdata0/1/2` into the operand registers that drive `mac_vector_a`, `mac_vector_b`, `mac_vd`.
  - Go to EXEC.
- **EXEC**
  - `mac_valid=1`. Operands stay stable.
  - On `mac_done=1`, capture `mac_result` into the result register and go to WB.
  - `mac_done` seen outside EXEC is ignored.
- **WB**
  - `rf_we=1` for one cycle.
  - `rf_waddr=vd_idx`, `rf_wdata`=result register.
  - `rf_wstrb[i]=1` iff i < clamped `vl`.
  - `instr_done` pulses in the same cycle.
  - Return to IDLE.
- `instr_ready` is 0 in every state except IDLE. Back-to-back instructions are accepted in the first IDLE cycle after WB.
- A `vd_idx` equal to `vs1` or `vs2` is legal. Reads complete before the writeback, so there is no hazard.
- Reset, including mid-instruction:
  - State returns to IDLE and the latched instruction is discarded.
  - `rf_ren`, `rf_we`, `mac_valid`, `instr_done`, `err` are 0.
  - `rf_wstrb`, `rf_waddr`, `rf_raddr*`, operand and result registers are 0.
  - `instr_ready` is 1 from the first cycle after reset is sampled.

## Timing
- Accept at cycle 0 (handshake).
- RD at cycle 1, CAP at cycle 2, EXEC from cycle 3.
- If `mac_done` arrives at cycle 3+k (k≥0), WB and `instr_done` are at cycle 4+k, and IDLE is at cycle 5+k.
- Minimum occupancy is 5 cycles with a same-cycle `mac_done`.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Configuration
- `VMAC_TIMEOUT_EN` defined:
  - A counter runs in EXEC.
  - If `mac_done` has not arrived after `TIMEOUT` EXEC cycles, the sequencer drops `mac_valid`, sets `err` (sticky until reset) and pulses `instr_done` with `rf_we=0`, then returns to IDLE.
  - `mac_done` on the final counted cycle wins over the timeout.
- `VMAC_TIMEOUT_EN` undefined:
  - EXEC waits indefinitely.
  - `err` is tied to 0 and the counter is absent.

## Test plan
- Basic operation:
  - Stimulus: `vs1=1`, `vs2=2`, `vd_idx=3`, `vl=8`; the register-file model returns a=0x0003 per element, b=0x0004, vd=0x10; the MAC model raises `mac_done` at cycle 3 with per-element `result`=0x1C.
  - Required response: `rf_we` at cycle 4, `rf_waddr=3`, `rf_wstrb=8'hFF`, every element 0x1C, `instr_done` at cycle 4.
- Partial `vl`: `vl=5` -> `rf_wstrb=8'h1F`. `vl=12` -> clamped, `rf_wstrb=8'hFF`.
- Zero `vl`: `vl=0` -> no `rf_ren`, no `mac_valid`, `instr_done` one cycle after accept, `instr_ready` stays 1.
- MAC delay: `mac_done` delayed 10 cycles -> `mac_valid` high and operands stable for 11 cycles, WB at cycle 14. A second instruction offered during busy is not accepted until cycle 15.
- Reset mid-operation: `rst_n=0` during EXEC -> next cycle `mac_valid=0`, no writeback, `instr_ready=1`. A following instruction completes normally.
- Timeout (with `VMAC_TIMEOUT_EN`, `TIMEOUT=4`): `mac_done` never asserted -> `err=1` and `instr_done` after 4 EXEC cycles, `rf_we` never asserted. `err` remains 1 across later instructions until reset.
